// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART byte-stream boot loader writing the RV32I instruction memory
module uart_boot_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          MAX_WORDS      = 512,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_run,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [7:0]    count_lo;
    logic [15:0]   word_count;
    logic [15:0]   word_idx;
    logic [1:0]    byte_cnt;
    logic [31:0]   word_buf;
    logic [7:0]    csum;
    logic [TW-1:0] timer;
    logic [15:0]   len_full;
    logic          timed;
    logic          timeout_hit;
    logic          last_byte;

    assign len_full    = {rx_data, count_lo};
    assign timed       = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                         (state == ST_DATA)   || (state == ST_CSUM);
    assign timeout_hit = timed && !rx_valid && (timer == TW'(TIMEOUT_CYCLES - 1));
    // Fourth byte of the final word: the write goes out as the FSM enters CSUM
    assign last_byte   = (byte_cnt == 2'd3) && (word_idx == word_count - 16'd1);

    assign core_run    = (state == ST_DONE);
    assign load_error  = (state == ST_ERROR);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_SYNC;
        else        state <= next_state;
    end

    // Next-state decode; an idle timeout inside a frame overrides everything
    always_comb begin
        next_state = state;
        case (state)
            ST_SYNC:   if (rx_valid && rx_data == SYNC_BYTE) next_state = ST_LEN_LO;
            ST_LEN_LO: if (rx_valid) next_state = ST_LEN_HI;
            ST_LEN_HI: begin
                if (rx_valid) begin
                    if (len_full > 16'(MAX_WORDS)) next_state = ST_ERROR;
                    else if (len_full == 16'd0)    next_state = ST_CSUM;
                    else                           next_state = ST_DATA;
                end
            end
            ST_DATA:   if (rx_valid && last_byte) next_state = ST_CSUM;
            ST_CSUM:   if (rx_valid) next_state = (rx_data == csum) ? ST_DONE : ST_ERROR;
            ST_DONE:   next_state = ST_DONE;
            ST_ERROR:  if (rx_valid && rx_data == SYNC_BYTE) next_state = ST_LEN_LO;
            default:   next_state = ST_SYNC;
        endcase
        if (timeout_hit) next_state = ST_ERROR;
    end

    // Idle counter: runs only inside a frame, cleared by every accepted byte
    always_ff @(posedge clk) begin
        if (!rst_n || !timed || rx_valid) timer <= '0;
        else                              timer <= timer + TW'(1);
    end

    // Frame datapath: length latch, word assembly, checksum and memory write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_lo     <= 8'd0;
            word_count   <= 16'd0;
            word_idx     <= 16'd0;
            byte_cnt     <= 2'd0;
            word_buf     <= 32'd0;
            csum         <= 8'd0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'd0;
            words_loaded <= 16'd0;
        end else begin
            imem_we <= 1'b0;
            if (rx_valid) begin
                case (state)
                    ST_LEN_LO: count_lo <= rx_data;
                    ST_LEN_HI: begin
                        if (len_full <= 16'(MAX_WORDS)) begin
                            word_count   <= len_full;
                            word_idx     <= 16'd0;
                            byte_cnt     <= 2'd0;
                            csum         <= 8'd0;
                            words_loaded <= 16'd0;
                        end
                    end
                    ST_DATA: begin
                        word_buf <= {rx_data, word_buf[31:8]};
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_wdata   <= {rx_data, word_buf[31:8]};
                            imem_addr    <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            word_idx     <= word_idx + 16'd1;
                            words_loaded <= words_loaded + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
